// File: rtl/overlay_text_mixer.sv
// Character-cell text overlay mixed over a core video stream, 3 ce_pix stages of latency.
// Build option: define OVERLAY_TEXT_BLEND_EN to blend opaque background cells 50/50 with core video.
module overlay_text_mixer #(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 8,
  parameter int X_OFF  = 0,
  parameter int Y_OFF  = 0,
  parameter int VA_W   = $clog2(COLS * ROWS),
  parameter int FA_W   = 8 + $clog2(CHAR_H)
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ce_pix,
  input  logic            en,
  input  logic [7:0]      in_r,
  input  logic [7:0]      in_g,
  input  logic [7:0]      in_b,
  input  logic            in_hs,
  input  logic            in_vs,
  input  logic            in_de,
  input  logic            vram_we,
  input  logic [VA_W-1:0] vram_addr,
  input  logic [15:0]     vram_din,
  input  logic            font_we,
  input  logic [FA_W-1:0] font_addr,
  input  logic [7:0]      font_din,
  output logic [7:0]      out_r,
  output logic [7:0]      out_g,
  output logic [7:0]      out_b,
  output logic            out_hs,
  output logic            out_vs,
  output logic            out_de
);

  localparam int CW_LOG = $clog2(CHAR_W);
  localparam int CH_LOG = $clog2(CHAR_H);
  localparam int PX_W   = (CW_LOG > 0) ? CW_LOG : 1;
  localparam int PY_W   = (CH_LOG > 0) ? CH_LOG : 1;
  localparam int CELLS  = COLS * ROWS;
  localparam int FONT_D = 2 ** FA_W;
  localparam logic [15:0]     X_LO    = 16'(X_OFF);
  localparam logic [15:0]     Y_LO    = 16'(Y_OFF);
  localparam logic [15:0]     X_SPAN  = 16'(COLS * CHAR_W);
  localparam logic [15:0]     Y_SPAN  = 16'(ROWS * CHAR_H);
  localparam logic [15:0]     COLS_W  = 16'(COLS);
  localparam logic [15:0]     CW_MASK = 16'(CHAR_W - 1);
  localparam logic [PY_W-1:0] PY_MAX  = PY_W'(CHAR_H - 1);

  function automatic logic [7:0] chan_level(input logic on, input logic inten);
    case ({on, inten})
      2'b11:   chan_level = 8'hFF;
      2'b10:   chan_level = 8'hAA;
      2'b01:   chan_level = 8'h55;
      default: chan_level = 8'h00;
    endcase
  endfunction

  function automatic logic [23:0] irgb_expand(input logic [3:0] irgb);
    irgb_expand = {chan_level(irgb[2], irgb[3]), chan_level(irgb[1], irgb[3]),
                   chan_level(irgb[0], irgb[3])};
  endfunction

`ifdef OVERLAY_TEXT_BLEND_EN
  function automatic logic [23:0] blend_half(input logic [23:0] a, input logic [23:0] b);
    logic [8:0] sum_r, sum_g, sum_b;
    sum_r = {1'b0, a[23:16]} + {1'b0, b[23:16]};
    sum_g = {1'b0, a[15:8]}  + {1'b0, b[15:8]};
    sum_b = {1'b0, a[7:0]}   + {1'b0, b[7:0]};
    blend_half = {sum_r[8:1], sum_g[8:1], sum_b[8:1]};
  endfunction
`endif

  logic [15:0]     x_r, y_r, rb_r;
  logic [PY_W-1:0] py_r;
  logic            de_d_r, vs_d_r;
  logic            de_fall_s, vs_rise_s, y_upd_s;
  logic [15:0]     y_nxt_s, rb_nxt_s;
  logic [PY_W-1:0] py_nxt_s;
  logic [16:0]     x_diff_s, y_diff_s;
  logic            win_s;
  logic [15:0]     col_s;
  logic [PX_W-1:0] px_s;
  logic [VA_W-1:0] vaddr_s;
  logic [FA_W-1:0] faddr_s;

  logic [15:0] vram_mem [0:CELLS-1];
  logic [7:0]  font_mem [0:FONT_D-1];
  logic [15:0] vram_q_r;
  logic [7:0]  font_q_r;

  logic            s1_win_r, s1_en_r, s1_hs_r, s1_vs_r, s1_de_r;
  logic [PX_W-1:0] s1_px_r;
  logic [PY_W-1:0] s1_py_r;
  logic [23:0]     s1_rgb_r;
  logic            s2_win_r, s2_en_r, s2_hs_r, s2_vs_r, s2_de_r;
  logic [PX_W-1:0] s2_px_r;
  logic [7:0]      s2_attr_r;
  logic [23:0]     s2_rgb_r;
  logic            glyph_bit_s;
  logic [23:0]     mix_s;

  // Line counter update; a vsync rise overrides a same-pixel de fall
  always_comb begin
    de_fall_s = de_d_r & ~in_de;
    vs_rise_s = in_vs & ~vs_d_r;
    y_nxt_s   = y_r;
    y_upd_s   = 1'b0;
    py_nxt_s  = py_r;
    rb_nxt_s  = rb_r;
    if (vs_rise_s) begin
      y_nxt_s = 16'd0;
      y_upd_s = 1'b1;
    end else if (de_fall_s) begin
      y_nxt_s = y_r + 16'd1;
      y_upd_s = 1'b1;
    end else begin
      y_upd_s = 1'b0;
    end
    // Row base advances by COLS per cell row, so no row*COLS multiply is needed
    if (y_upd_s && (y_nxt_s == Y_LO)) begin
      py_nxt_s = {PY_W{1'b0}};
      rb_nxt_s = 16'd0;
    end else if (y_upd_s && (y_nxt_s > Y_LO)) begin
      if (py_r == PY_MAX) begin
        py_nxt_s = {PY_W{1'b0}};
        rb_nxt_s = rb_r + COLS_W;
      end else begin
        py_nxt_s = py_r + PY_W'(1);
      end
    end else begin
      py_nxt_s = py_r;
    end
  end

  // Window decode and VRAM address for the incoming pixel
  always_comb begin
    x_diff_s = {1'b0, x_r} - {1'b0, X_LO};
    y_diff_s = {1'b0, y_r} - {1'b0, Y_LO};
    win_s    = in_de & ~x_diff_s[16] & (x_diff_s[15:0] < X_SPAN)
                     & ~y_diff_s[16] & (y_diff_s[15:0] < Y_SPAN);
    col_s    = x_diff_s[15:0] >> CW_LOG;
    px_s     = PX_W'(x_diff_s[15:0] & CW_MASK);
    if (win_s) begin
      vaddr_s = VA_W'(rb_r + col_s);
    end else begin
      vaddr_s = {VA_W{1'b0}};
    end
    faddr_s = (FA_W'(vram_q_r[7:0]) << CH_LOG) | FA_W'(s1_py_r);
  end

  // Pixel and line counters
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      x_r    <= 16'd0;
      y_r    <= 16'd0;
      rb_r   <= 16'd0;
      py_r   <= {PY_W{1'b0}};
      de_d_r <= 1'b0;
      vs_d_r <= 1'b0;
    end else if (ce_pix) begin
      x_r    <= in_de ? (x_r + 16'd1) : 16'd0;
      y_r    <= y_nxt_s;
      rb_r   <= rb_nxt_s;
      py_r   <= py_nxt_s;
      de_d_r <= in_de;
      vs_d_r <= in_vs;
    end
  end

  // Cell RAM: host write port, pipeline read port (read-before-write)
  always_ff @(posedge clk_sys) begin
    if (vram_we && (32'(vram_addr) < 32'(CELLS))) begin
      vram_mem[vram_addr] <= vram_din;
    end
    if (ce_pix) begin
      vram_q_r <= vram_mem[vaddr_s];
    end
  end

  // Font RAM: host write port, pipeline read port (read-before-write)
  always_ff @(posedge clk_sys) begin
    if (font_we) begin
      font_mem[font_addr] <= font_din;
    end
    if (ce_pix) begin
      font_q_r <= font_mem[faddr_s];
    end
  end

  // Stages 1 and 2: carry timing, core colour and cell position alongside the RAM reads
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_win_r  <= 1'b0;
      s1_en_r   <= 1'b0;
      s1_hs_r   <= 1'b0;
      s1_vs_r   <= 1'b0;
      s1_de_r   <= 1'b0;
      s1_px_r   <= {PX_W{1'b0}};
      s1_py_r   <= {PY_W{1'b0}};
      s1_rgb_r  <= 24'h000000;
      s2_win_r  <= 1'b0;
      s2_en_r   <= 1'b0;
      s2_hs_r   <= 1'b0;
      s2_vs_r   <= 1'b0;
      s2_de_r   <= 1'b0;
      s2_px_r   <= {PX_W{1'b0}};
      s2_attr_r <= 8'h00;
      s2_rgb_r  <= 24'h000000;
    end else if (ce_pix) begin
      s1_win_r  <= win_s;
      s1_en_r   <= en;
      s1_hs_r   <= in_hs;
      s1_vs_r   <= in_vs;
      s1_de_r   <= in_de;
      s1_px_r   <= px_s;
      s1_py_r   <= py_r;
      s1_rgb_r  <= {in_r, in_g, in_b};
      s2_win_r  <= s1_win_r;
      s2_en_r   <= s1_en_r;
      s2_hs_r   <= s1_hs_r;
      s2_vs_r   <= s1_vs_r;
      s2_de_r   <= s1_de_r;
      s2_px_r   <= s1_px_r;
      s2_attr_r <= vram_q_r[15:8];
      s2_rgb_r  <= s1_rgb_r;
    end
  end

  // Stage 3 colour selection; bit 7 of the font byte is the leftmost pixel
  always_comb begin
    glyph_bit_s = font_q_r[3'd7 - 3'(s2_px_r)];
    mix_s       = s2_rgb_r;
    if (s2_win_r && s2_en_r) begin
      if (glyph_bit_s) begin
        mix_s = irgb_expand(s2_attr_r[3:0]);
      end else if (s2_attr_r[7:4] != 4'h0) begin
`ifdef OVERLAY_TEXT_BLEND_EN
        mix_s = blend_half(irgb_expand(s2_attr_r[7:4]), s2_rgb_r);
`else
        mix_s = irgb_expand(s2_attr_r[7:4]);
`endif
      end else begin
        mix_s = s2_rgb_r;
      end
    end else begin
      mix_s = s2_rgb_r;
    end
  end

  // Registered outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      out_r  <= 8'h00;
      out_g  <= 8'h00;
      out_b  <= 8'h00;
      out_hs <= 1'b0;
      out_vs <= 1'b0;
      out_de <= 1'b0;
    end else if (ce_pix) begin
      {out_r, out_g, out_b} <= mix_s;
      out_hs <= s2_hs_r;
      out_vs <= s2_vs_r;
      out_de <= s2_de_r;
    end
  end

endmodule
